// File: rtl/mult_arbiter_if.sv
// Signal bundle between requesters A/B, the arbiter and the shared multiplier.
// The slave modport is the arbiter's view; master is the environment's view.
interface mult_arbiter_if;
    logic       req_a;
    logic [3:0] a_in_1;
    logic [3:0] a_in_2;
    logic       req_b;
    logic [3:0] b_in_1;
    logic [3:0] b_in_2;
    logic       done_a;
    logic       done_b;
    logic [7:0] res_a;
    logic [7:0] res_b;
    logic       busy;
    logic       mul_rst;
    logic       mul_start;
    logic [3:0] mul_in_1;
    logic [3:0] mul_in_2;
    logic [7:0] mul_out;

    modport slave (
        input  req_a, a_in_1, a_in_2, req_b, b_in_1, b_in_2, mul_out,
        output done_a, done_b, res_a, res_b, busy, mul_rst, mul_start, mul_in_1, mul_in_2
    );

    modport master (
        output req_a, a_in_1, a_in_2, req_b, b_in_1, b_in_2, mul_out,
        input  done_a, done_b, res_a, res_b, busy, mul_rst, mul_start, mul_in_1, mul_in_2
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 4x4 multiplier between requesters A and B.
// Optional feature macro MULT_ARB_ZERO_BYPASS_EN: grants with a zero operand skip the multiplier.
//
// state | meaning
// IDLE  | no operation; arbitrate pending reqs and latch the winner's operands
// START | mul_start pulse, wait counter loaded with MUL_LAT-1
// WAIT  | count down the multiplier latency
// DONE  | product captured into owner's res, owner's done pulse, pointer updated
module mult_arbiter #(
    parameter int MUL_LAT = 10
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_b_q, owner_b_d;
    logic          last_b_q, last_b_d;
    logic          busy_q, busy_d;
    logic          mul_start_q, mul_start_d;
    logic          done_a_q, done_a_d;
    logic          done_b_q, done_b_d;
    logic [7:0]    res_a_q, res_a_d;
    logic [7:0]    res_b_q, res_b_d;
    logic [3:0]    mul_in_1_q, mul_in_1_d;
    logic [3:0]    mul_in_2_q, mul_in_2_d;
    logic          grant_b;
    logic [3:0]    op_1, op_2;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_b_d   = owner_b_q;
        last_b_d    = last_b_q;
        mul_start_d = 1'b0;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        mul_in_1_d  = mul_in_1_q;
        mul_in_2_d  = mul_in_2_q;
        // B wins when alone, or when both request and A was served last
        grant_b     = bus.req_b && (!bus.req_a || !last_b_q);
        op_1        = grant_b ? bus.b_in_1 : bus.a_in_1;
        op_2        = grant_b ? bus.b_in_2 : bus.a_in_2;

        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    owner_b_d  = grant_b;
                    mul_in_1_d = op_1;
                    mul_in_2_d = op_2;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                    if (op_1 == 4'd0 || op_2 == 4'd0) begin
                        state_d = DONE;
                        if (grant_b) begin
                            res_b_d  = 8'd0;
                            done_b_d = 1'b1;
                        end else begin
                            res_a_d  = 8'd0;
                            done_a_d = 1'b1;
                        end
                    end else begin
                        state_d     = START;
                        mul_start_d = 1'b1;
                    end
`else
                    state_d     = START;
                    mul_start_d = 1'b1;
`endif
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = CW'(MUL_LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (owner_b_q) begin
                        res_b_d  = bus.mul_out;
                        done_b_d = 1'b1;
                    end else begin
                        res_a_d  = bus.mul_out;
                        done_a_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                last_b_d = owner_b_q;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_b_q   <= 1'b0;
            last_b_q    <= 1'b1;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            res_a_q     <= 8'd0;
            res_b_q     <= 8'd0;
            mul_in_1_q  <= 4'd0;
            mul_in_2_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_b_q   <= owner_b_d;
            last_b_q    <= last_b_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            mul_in_1_q  <= mul_in_1_d;
            mul_in_2_q  <= mul_in_2_d;
        end
    end

    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.res_a     = res_a_q;
    assign bus.res_b     = res_b_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_in_1  = mul_in_1_q;
    assign bus.mul_in_2  = mul_in_2_q;
    assign bus.mul_rst   = ~rst;
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: timeline reference model plus a latency-accurate multiplier model,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_mult_arbiter;
    localparam int L = 10;

    logic clk;
    logic rst;
    mult_arbiter_if bus ();

    mult_arbiter #(.MUL_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Multiplier: product valid from MUL_LAT cycles after the start pulse; complement before that
    logic [7:0] mm_prod = 8'd0;
    int         mm_cnt  = 0;
    logic       mm_vld  = 1'b0;
    always @(posedge clk or posedge bus.mul_rst) begin
        if (bus.mul_rst) begin
            mm_prod <= 8'd0;
            mm_cnt  <= 0;
            mm_vld  <= 1'b0;
        end else if (bus.mul_start) begin
            mm_prod <= {4'd0, bus.mul_in_1} * {4'd0, bus.mul_in_2};
            mm_cnt  <= L - 1;
            mm_vld  <= 1'b1;
        end else if (mm_cnt != 0) begin
            mm_cnt <= mm_cnt - 1;
        end
    end
    assign bus.mul_out = (mm_vld && mm_cnt == 0) ? mm_prod : ~mm_prod;

    // Reference model: one operation at a time, described by its grant edge and done offset
    bit         m_busy  = 1'b0;
    bit         m_owner = 1'b0;
    bit         m_last  = 1'b1;
    bit         m_byp   = 1'b0;
    int         m_g     = 0;
    int         m_nd    = 0;
    int         m_age   = 0;
    logic [3:0] m_in1   = 4'd0;
    logic [3:0] m_in2   = 4'd0;
    logic [7:0] m_prod  = 8'd0;
    logic [7:0] e_res_a = 8'd0;
    logic [7:0] e_res_b = 8'd0;
    bit         e_start = 1'b0;
    bit         e_done_a = 1'b0;
    bit         e_done_b = 1'b0;
    bit         e_busy  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_in1 = 4'd0; m_in2 = 4'd0;
            e_res_a = 8'd0; e_res_b = 8'd0;
            e_start = 1'b0; e_done_a = 1'b0; e_done_b = 1'b0; e_busy = 1'b0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc - m_g == m_nd + 1) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end else if (bus.req_a || bus.req_b) begin
                if (bus.req_a && bus.req_b) m_owner = !m_last;
                else                        m_owner = bus.req_b;
                m_in1  = m_owner ? bus.b_in_1 : bus.a_in_1;
                m_in2  = m_owner ? bus.b_in_2 : bus.a_in_2;
                m_prod = {4'd0, m_in1} * {4'd0, m_in2};
                m_byp  = 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                m_byp  = (m_in1 == 4'd0) || (m_in2 == 4'd0);
`endif
                m_nd   = m_byp ? 0 : L + 1;
                m_g    = cyc;
                m_busy = 1'b1;
            end
            m_age    = cyc - m_g;
            e_busy   = m_busy;
            e_start  = m_busy && !m_byp && (m_age == 0);
            e_done_a = m_busy && (m_age == m_nd) && !m_owner;
            e_done_b = m_busy && (m_age == m_nd) && m_owner;
            if (e_done_a) e_res_a = m_prod;
            if (e_done_b) e_res_b = m_prod;
        end
    end

    always @(negedge clk) begin
        chk("done_a", bus.done_a, e_done_a);
        chk("done_b", bus.done_b, e_done_b);
        chk("res_a", bus.res_a, e_res_a);
        chk("res_b", bus.res_b, e_res_b);
        chk("busy", bus.busy, e_busy);
        chk("mul_start", bus.mul_start, e_start);
        chk("mul_in_1", bus.mul_in_1, m_in1);
        chk("mul_in_2", bus.mul_in_2, m_in2);
        chk("mul_rst", bus.mul_rst, !rst);
        if (bus.mul_start) n_start++;
    end

    // Returns the spec cycle label of the done pulse, or -1 after a bounded wait
    task automatic wait_done(input bit is_b, input string nm, output int c);
        bit seen;
        seen = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (is_b ? bus.done_b : bus.done_a) begin
                seen = 1'b1;
                c = cyc + 1;
            end
        end
        chk({nm, "_seen"}, seen, 1);
    endtask

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(0, 5) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic step_req(input logic done_i, input bit own_busy, inout logic req,
                            inout logic [3:0] o1, inout logic [3:0] o2);
        if (!req) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b1; o1 = rnd_op(); o2 = rnd_op();
            end
        end else if (done_i) begin
            if ($urandom_range(0, 1) == 0) req = 1'b0;
            else begin o1 = rnd_op(); o2 = rnd_op(); end
        end else if (own_busy && $urandom_range(0, 15) == 0) begin
            req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            o1 = rnd_op(); o2 = rnd_op();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int k, dc, dc2, ns0;
        int seq[4];
        int nd;
        rst = 1'b0;
        bus.req_a = 1'b0; bus.a_in_1 = 4'd0; bus.a_in_2 = 4'd0;
        bus.req_b = 1'b0; bus.b_in_1 = 4'd0; bus.b_in_2 = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_a", bus.res_a, 0);
        chk("rst_mul_rst", bus.mul_rst, 1);
        chk("rst_mul_start", bus.mul_start, 0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // single A op 6x9
        bus.req_a = 1'b1; bus.a_in_1 = 4'd6; bus.a_in_2 = 4'd9;
        k = cyc + 1;
        wait_done(1'b0, "r19", dc);
        bus.req_a = 1'b0;
        chk("r19_done_lat", dc - k, 12);
        chk("r19_res_a", bus.res_a, 8'h36);
        chk("r19_res_b", bus.res_b, 8'h00);
        repeat (2) @(negedge clk);

        // simultaneous requests after reset: A first, then B
        do_reset();
        bus.req_a = 1'b1; bus.a_in_1 = 4'd3; bus.a_in_2 = 4'd5;
        bus.req_b = 1'b1; bus.b_in_1 = 4'd7; bus.b_in_2 = 4'd7;
        wait_done(1'b0, "r20a", dc);
        chk("r20_busy_a", bus.busy, 1);
        chk("r20_res_a", bus.res_a, 8'd15);
        bus.req_a = 1'b0;
        wait_done(1'b1, "r20b", dc2);
        chk("r20_busy_b", bus.busy, 1);
        chk("r20_res_b", bus.res_b, 8'd49);
        chk("r20_gap", dc2 - dc, 13);
        bus.req_b = 1'b0;
        repeat (2) @(negedge clk);

        // both held for four operations: alternation A,B,A,B
        bus.req_a = 1'b1; bus.a_in_1 = 4'd2; bus.a_in_2 = 4'd3;
        bus.req_b = 1'b1; bus.b_in_1 = 4'd4; bus.b_in_2 = 4'd5;
        nd = 0;
        for (int i = 0; i < 200 && nd < 4; i++) begin
            @(negedge clk);
            if (bus.done_a) begin seq[nd] = 0; nd++; end
            else if (bus.done_b) begin seq[nd] = 1; nd++; end
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        chk("r21_count", nd, 4);
        chk("r21_g0", seq[0], 0);
        chk("r21_g1", seq[1], 1);
        chk("r21_g2", seq[2], 0);
        chk("r21_g3", seq[3], 1);
        repeat (2) @(negedge clk);

        // reset during B's WAIT, then B is regranted
        bus.req_b = 1'b1; bus.b_in_1 = 4'd5; bus.b_in_2 = 4'd6;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r22_busy", bus.busy, 0);
        chk("r22_done_b", bus.done_b, 0);
        chk("r22_res_a", bus.res_a, 0);
        chk("r22_res_b", bus.res_b, 0);
        chk("r22_mul_in_1", bus.mul_in_1, 0);
        chk("r22_mul_rst", bus.mul_rst, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        k = cyc + 1;
        wait_done(1'b1, "r22", dc);
        bus.req_b = 1'b0;
        chk("r22_done_lat", dc - k, 12);
        chk("r22_res_b_after", bus.res_b, 8'd30);
        repeat (2) @(negedge clk);

        // 15x15 on B
        bus.req_b = 1'b1; bus.b_in_1 = 4'd15; bus.b_in_2 = 4'd15;
        wait_done(1'b1, "r23", dc);
        bus.req_b = 1'b0;
        chk("r23_res_b", bus.res_b, 8'hE1);
        repeat (2) @(negedge clk);

        // zero operand on A, preceded by a nonzero A result
        bus.req_a = 1'b1; bus.a_in_1 = 4'd3; bus.a_in_2 = 4'd4;
        wait_done(1'b0, "r24pre", dc);
        bus.req_a = 1'b0;
        chk("r24_pre_res_a", bus.res_a, 8'd12);
        repeat (2) @(negedge clk);
        ns0 = n_start;
        bus.req_a = 1'b1; bus.a_in_1 = 4'd0; bus.a_in_2 = 4'd9;
        k = cyc + 1;
        wait_done(1'b0, "r24", dc);
        bus.req_a = 1'b0;
        @(negedge clk);
        chk("r24_res_a", bus.res_a, 8'd0);
`ifdef MULT_ARB_ZERO_BYPASS_EN
        chk("r24_done_lat", dc - k, 1);
        chk("r24_starts", n_start - ns0, 0);
`else
        chk("r24_done_lat", dc - k, 12);
        chk("r24_starts", n_start - ns0, 1);
`endif
        repeat (2) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
                continue;
            end
            step_req(bus.done_a, m_busy && !m_owner, bus.req_a, bus.a_in_1, bus.a_in_2);
            step_req(bus.done_b, m_busy && m_owner, bus.req_b, bus.b_in_1, bus.b_in_2);
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
